// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit per cycle: W cycles of work, then a one-cycle done pulse.
module bin2bcd_seq #(
    parameter int W = 16,
    parameter int D = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic [4*D-1:0] bcd,
    output logic           ready,
    output logic           done_tick
);

    localparam int NW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OP   = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [4*D-1:0] dig_q, dig_d;
    logic [4*D-1:0] adj;
    logic [NW-1:0]  n_q, n_d;
    logic [4*D-1:0] bcd_q, bcd_d;

    // Per-digit +3 correction ahead of the shift; no carry between digits.
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < D; i++) begin
            if (dig_q[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            dig_q   <= '0;
            n_q     <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            dig_q   <= dig_d;
            n_q     <= n_d;
            bcd_q   <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        dig_d   = dig_q;
        n_d     = n_q;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_OP;
                    sh_d    = bin;
                    dig_d   = '0;
                    n_d     = NW'(W);
                end
            end
            S_OP: begin
                dig_d = {adj[4*D-2:0], sh_q[W-1]};
                sh_d  = sh_q << 1;
                n_d   = n_q - NW'(1);
                if (n_q == NW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = dig_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done_tick is seen.
module tb_bin2bcd_seq;

    localparam int W = 16;
    localparam int D = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   bin;
    logic [4*D-1:0] bcd;
    logic           ready;
    logic           done_tick;

    always #5 clk = ~clk;

    bin2bcd_seq #(.W(W), .D(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .bcd      (bcd),
        .ready    (ready),
        .done_tick(done_tick)
    );

    typedef struct {
        logic [4*D-1:0] bcd;
        int             acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done_tick must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset && done_tick) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_tick=1 bcd=%h, expected none",
                         bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("latency", cyc - e.acc, W);
                check("ready_in_done", 32'(ready), 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0, expected 1 within 200 cycles");
        end
    endtask

    task automatic convert(input logic [W-1:0] b, input logic [4*D-1:0] e);
        wait_ready();
        bin   = b;
        start = 1'b1;
        sb.push_back('{e, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        check("ready_op", 32'(ready), 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (!(sb.size() == 0 && ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || !ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before 400us");
        $fatal(1);
    end

    initial begin
        int last;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        #12;
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(16'd0, 20'h00000);
        drain();

        convert(16'd5, 20'h00005);
        drain();
        convert(16'd123, 20'h00123);
        repeat (5) @(negedge clk);
        check("bcd_hold", 32'(bcd), 32'h00005);
        drain();

        convert(16'd65535, 20'h65535);
        convert(16'd9999,  20'h09999);
        convert(16'd9,     20'h00009);
        convert(16'd10,    20'h00010);
        convert(16'd99,    20'h00099);
        convert(16'd100,   20'h00100);
        convert(16'd10000, 20'h10000);
        convert(16'd32768, 20'h32768);
        convert(16'd59999, 20'h59999);
        drain();

        // Starts during op must be ignored, not queued.
        wait_ready();
        bin   = 16'd42;
        start = 1'b1;
        sb.push_back('{20'h00042, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        bin   = 16'd777;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_ignore", 32'(ready), 32'd0);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        check("no_queue_ready", 32'(ready), 32'd1);

        // Back-to-back with start held high.
        wait_ready();
        bin   = 16'd300;
        start = 1'b1;
        last  = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            sb.push_back('{20'h00300, cyc + 1});
            if (i > 0) check("b2b_period", cyc - last, W + 2);
            last = cyc;
            @(negedge clk);
            check("b2b_ready_1cyc", 32'(ready), 32'd0);
        end
        start = 1'b0;
        drain();

        // Abort mid-conversion with reset.
        convert(16'd4321, 20'h04321);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete(sb.size() - 1);
        #1;
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) @(negedge clk);
        convert(16'd4321, 20'h04321);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
